// File: rtl/db_req.sv
// db_req: SRIO doorbell initiator. Sends a query DOORB on ireq, waits on iresp for the
// remote endpoint's ready/not-ready doorbell, and retries with a backoff gap.
module db_req #(
    parameter logic [15:0] QUERY_INFO = 16'h0001,
    parameter logic [15:0] TIMEOUT    = 16'd4096,
    parameter logic [15:0] RETRY_GAP  = 16'd256,
    parameter logic [3:0]  MAX_RETRY  = 4'd8
) (
    input  logic        log_clk,
    input  logic        log_rst,
    input  logic [15:0] src_id,
    input  logic [15:0] des_id,
    input  logic        start_in,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic        ed_ready_o,
    output logic [3:0]  retry_cnt_o,
    input  logic        ireq_tready_in,
    output logic        ireq_tvalid_o,
    output logic        ireq_tlast_o,
    output logic [63:0] ireq_tdata_o,
    output logic [7:0]  ireq_tkeep_o,
    output logic [31:0] ireq_tuser_o,
    input  logic        iresp_tvalid_in,
    output logic        iresp_tready_o,
    input  logic        iresp_tlast_in,
    input  logic [63:0] iresp_tdata_in,
    input  logic [7:0]  iresp_tkeep_in,
    input  logic [31:0] iresp_tuser_in
);
    localparam logic [15:0] TIMER_LAST     = TIMEOUT - 16'd1;
    localparam logic [15:0] GAP_LAST       = RETRY_GAP - 16'd1;
    localparam logic [15:0] INFO_READY     = 16'h0100;
    localparam logic [15:0] INFO_NOT_READY = 16'h01FF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_BACKOFF   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_tid;
    logic [15:0] r_timer;
    logic [15:0] r_gap;
    logic [3:0]  r_retry;
    logic        r_first;
    logic        r_busy;
    logic        r_done;
    logic        r_fail;
    logic        r_ed_ready;

    logic        w_start;
    logic        w_ireq_hs;
    logic        w_match;
    logic [15:0] w_info;
    logic        w_done_set;
    logic        w_fail_set;
    logic        w_retry_inc;
    logic [63:0] w_query;
    logic        w_unused;

    // Both channels are AXI-Stream: a beat transfers on a rising edge where tvalid and
    // tready are both high; ireq holds tvalid and tdata stable until that edge.
    assign w_start   = (r_state == S_IDLE) && start_in;
    assign w_ireq_hs = (r_state == S_SEND) && ireq_tready_in;
    assign w_info    = iresp_tdata_in[31:16];
    assign w_match   = iresp_tvalid_in && r_first && (iresp_tdata_in[55:52] == 4'hA) &&
                       (iresp_tuser_in[31:16] == des_id) && (r_state == S_WAIT_RESP);
    assign w_query   = {r_tid, 4'hA, 4'h0, 1'b0, 2'h1, 1'b0, 12'h000, QUERY_INFO, 16'h0000};

    always_comb begin
        w_next      = r_state;
        w_done_set  = 1'b0;
        w_fail_set  = 1'b0;
        w_retry_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_in) w_next = S_SEND;
            end
            S_SEND: begin
                if (ireq_tready_in) w_next = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                // A decisive response beats a timer expiry on the same cycle.
                if (w_match && (w_info == INFO_READY)) begin
                    w_next     = S_IDLE;
                    w_done_set = 1'b1;
                end else if ((w_match && (w_info == INFO_NOT_READY)) || (r_timer == TIMER_LAST)) begin
                    w_next = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                if (r_retry == MAX_RETRY) begin
                    w_next     = S_IDLE;
                    w_fail_set = 1'b1;
                end else if (r_gap == GAP_LAST) begin
                    w_next      = S_SEND;
                    w_retry_inc = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            r_tid      <= 8'h00;
            r_timer    <= 16'd0;
            r_gap      <= 16'd0;
            r_retry    <= 4'd0;
            r_first    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_ed_ready <= 1'b0;
        end else begin
            r_done <= w_done_set;
            r_fail <= w_fail_set;
            if (w_start) begin
                r_busy     <= 1'b1;
                r_retry    <= 4'd0;
                r_ed_ready <= 1'b0;
            end
            if (w_done_set) begin
                r_busy     <= 1'b0;
                r_ed_ready <= 1'b1;
            end
            if (w_fail_set)  r_busy  <= 1'b0;
            if (w_retry_inc) r_retry <= r_retry + 4'd1;
            if (w_ireq_hs) begin
                r_tid   <= r_tid + 8'd1;
                r_timer <= 16'd0;
            end else if (r_state == S_WAIT_RESP) begin
                r_timer <= r_timer + 16'd1;
            end
            r_gap <= (r_state == S_BACKOFF) ? r_gap + 16'd1 : 16'd0;
            // iresp is always ready, so every valid beat is consumed.
            if (iresp_tvalid_in) r_first <= iresp_tlast_in;
        end
    end

    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign fail_o         = r_fail;
    assign ed_ready_o     = r_ed_ready;
    assign retry_cnt_o    = r_retry;
    assign ireq_tvalid_o  = (r_state == S_SEND);
    assign ireq_tlast_o   = ireq_tvalid_o;
    assign ireq_tkeep_o   = ireq_tvalid_o ? 8'hFF : 8'h00;
    assign ireq_tdata_o   = ireq_tvalid_o ? w_query : 64'd0;
    assign ireq_tuser_o   = ireq_tvalid_o ? {src_id, des_id} : 32'd0;
    assign iresp_tready_o = 1'b1;

    assign w_unused = ^{iresp_tkeep_in, iresp_tdata_in[63:56], iresp_tdata_in[51:32],
                        iresp_tdata_in[15:0], iresp_tuser_in[15:0]};
endmodule

// File: tb/tb_db_req.sv
// Bench for db_req: directed and randomized queries against a per-query outcome model,
// with a scoreboard of expected ireq beats and cycle-exact timing expectations.
module tb_db_req;
    localparam logic [15:0] QI = 16'h0001;
    localparam int T  = 16;
    localparam int RG = 4;
    localparam int MR = 2;
    localparam int OUT_READY    = 0;
    localparam int OUT_NOTREADY = 1;
    localparam int OUT_TIMEOUT  = 2;

    logic        log_clk = 1'b0;
    logic        log_rst = 1'b1;
    logic [15:0] src_id = '0, des_id = '0;
    logic        start_in = 1'b0;
    logic        busy_o, done_o, fail_o, ed_ready_o;
    logic [3:0]  retry_cnt_o;
    logic        ireq_tready_in = 1'b0;
    logic        ireq_tvalid_o, ireq_tlast_o;
    logic [63:0] ireq_tdata_o;
    logic [7:0]  ireq_tkeep_o;
    logic [31:0] ireq_tuser_o;
    logic        iresp_tvalid_in = 1'b0;
    logic        iresp_tready_o;
    logic        iresp_tlast_in = 1'b0;
    logic [63:0] iresp_tdata_in = '0;
    logic [7:0]  iresp_tkeep_in = '0;
    logic [31:0] iresp_tuser_in = '0;

    db_req #(.QUERY_INFO(QI), .TIMEOUT(16'd16), .RETRY_GAP(16'd4), .MAX_RETRY(4'd2)) dut (
        .log_clk(log_clk), .log_rst(log_rst), .src_id(src_id), .des_id(des_id),
        .start_in(start_in), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
        .ed_ready_o(ed_ready_o), .retry_cnt_o(retry_cnt_o),
        .ireq_tready_in(ireq_tready_in), .ireq_tvalid_o(ireq_tvalid_o),
        .ireq_tlast_o(ireq_tlast_o), .ireq_tdata_o(ireq_tdata_o),
        .ireq_tkeep_o(ireq_tkeep_o), .ireq_tuser_o(ireq_tuser_o),
        .iresp_tvalid_in(iresp_tvalid_in), .iresp_tready_o(iresp_tready_o),
        .iresp_tlast_in(iresp_tlast_in), .iresp_tdata_in(iresp_tdata_in),
        .iresp_tkeep_in(iresp_tkeep_in), .iresp_tuser_in(iresp_tuser_in)
    );

    // clock/reset
    always #5 log_clk = ~log_clk;
    int cyc = 0;
    always @(posedge log_clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int done_cnt = 0, fail_cnt = 0, both_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_user_q[$];
    logic [63:0] beat_q[$];
    logic [31:0] buser_q[$];
    logic [7:0]  mdl_tid = 8'h00;
    int plan_out[0:7];
    int plan_stall[0:7];
    int plan_dly[0:7];
    bit plan_glitch[0:7];

    // monitor, sampled on the falling edge
    always @(negedge log_clk) begin
        if (!log_rst && ireq_tvalid_o && ireq_tready_in) begin
            beat_q.push_back(ireq_tdata_o);
            buser_q.push_back(ireq_tuser_o);
        end
        if (done_o) done_cnt++;
        if (fail_o) fail_cnt++;
        if (done_o && fail_o) both_cnt++;
    end

    task automatic tick();
        @(posedge log_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] query_word(input logic [7:0] tid);
        return {tid, 4'hA, 4'h0, 1'b0, 2'h1, 1'b0, 12'h000, QI, 16'h0000};
    endfunction

    function automatic logic [63:0] resp_word(input logic [3:0] ftype, input logic [15:0] info);
        return {8'h00, ftype, 20'h00000, info, 16'h0000};
    endfunction

    task automatic send_beat(input logic [63:0] data, input logic [31:0] user, input logic last);
        iresp_tvalid_in = 1'b1;
        iresp_tdata_in  = data;
        iresp_tuser_in  = user;
        iresp_tlast_in  = last;
        iresp_tkeep_in  = 8'hFF;
        tick();
        iresp_tvalid_in = 1'b0;
        iresp_tlast_in  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_fail"}, fail_o, 0);
        check({tag, "_ed_ready"}, ed_ready_o, 0);
        check({tag, "_retry"}, retry_cnt_o, 0);
        check({tag, "_tvalid"}, ireq_tvalid_o, 0);
        check({tag, "_tlast"}, ireq_tlast_o, 0);
        check({tag, "_tdata"}, ireq_tdata_o, 0);
        check({tag, "_tkeep"}, ireq_tkeep_o, 0);
        check({tag, "_tuser"}, ireq_tuser_o, 0);
        check({tag, "_iresp_tready"}, iresp_tready_o, 1);
    endtask

    task automatic drain_scoreboard(input string tag);
        check({tag, "_beat_count"}, beat_q.size(), exp_q.size());
        while (beat_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_beat_data"}, beat_q.pop_front(), exp_q.pop_front());
            check({tag, "_beat_user"}, buser_q.pop_front(), exp_user_q.pop_front());
        end
        beat_q.delete(); buser_q.delete(); exp_q.delete(); exp_user_q.delete();
    endtask

    // Plays plan_* for one query; the expected outcome comes from the attempt list alone.
    task automatic run_query(input string tag, input logic [15:0] src, input logic [15:0] des);
        int n_sends, n, exp_v, exp_end, base_done, base_fail;
        bit exp_done;
        logic [63:0] d0;
        n_sends = 0;
        exp_done = 0;
        for (int i = 0; i <= MR; i++) begin
            if (!exp_done) begin
                n_sends++;
                if (plan_out[i] == OUT_READY) exp_done = 1;
            end
        end
        for (int i = 0; i < n_sends; i++) begin
            exp_q.push_back(query_word(mdl_tid));
            exp_user_q.push_back({src, des});
            mdl_tid++;
        end
        base_done = done_cnt;
        base_fail = fail_cnt;
        src_id = src;
        des_id = des;
        exp_end = 0;
        ireq_tready_in = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        exp_v = cyc;
        for (int i = 0; i < n_sends; i++) begin
            n = 0;
            while (!ireq_tvalid_o && n < 200) begin tick(); n++; end
            check({tag, "_send_cycle"}, cyc, exp_v);
            check({tag, "_busy_in_send"}, busy_o, 1);
            d0 = ireq_tdata_o;
            for (int s = 0; s < plan_stall[i]; s++) begin
                tick();
                check({tag, "_stall_valid"}, ireq_tvalid_o, 1);
                check({tag, "_stall_data"}, ireq_tdata_o, d0);
            end
            ireq_tready_in = 1'b1;
            tick();
            ireq_tready_in = 1'b0;
            check({tag, "_valid_drop"}, ireq_tvalid_o, 0);
            if (plan_out[i] == OUT_TIMEOUT) begin
                exp_v   = cyc + T + RG;
                exp_end = cyc + T + 1;
            end else begin
                for (int d = 0; d < plan_dly[i]; d++) begin
                    if (plan_glitch[i] && d == 0) start_in = 1'b1;
                    tick();
                    start_in = 1'b0;
                end
                send_beat(resp_word(4'hA, (plan_out[i] == OUT_READY) ? 16'h0100 : 16'h01FF),
                          {des, src}, 1'b1);
                exp_v   = cyc + RG;
                exp_end = cyc + 1;
                if (plan_out[i] == OUT_READY) begin
                    check({tag, "_done_pulse"}, done_o, 1);
                    check({tag, "_ed_ready"}, ed_ready_o, 1);
                    check({tag, "_busy_clear"}, busy_o, 0);
                end
            end
        end
        if (!exp_done) begin
            n = 0;
            while (!fail_o && n < 200) begin tick(); n++; end
            check({tag, "_fail_cycle"}, cyc, exp_end);
            check({tag, "_fail_pulse"}, fail_o, 1);
            check({tag, "_busy_clear"}, busy_o, 0);
            check({tag, "_ed_ready_low"}, ed_ready_o, 0);
        end
        check({tag, "_retry_cnt"}, retry_cnt_o, n_sends - 1);
        tick();
        check({tag, "_done_one_cycle"}, done_o, 0);
        check({tag, "_fail_one_cycle"}, fail_o, 0);
        check({tag, "_done_count"}, done_cnt - base_done, exp_done ? 1 : 0);
        check({tag, "_fail_count"}, fail_cnt - base_fail, exp_done ? 0 : 1);
        drain_scoreboard(tag);
        tick();
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 8; i++) begin
            plan_out[i] = OUT_READY; plan_stall[i] = 0; plan_dly[i] = 0; plan_glitch[i] = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_done, base_fail;
        logic [15:0] rs, rd;
        repeat (3) @(posedge log_clk);
        #1;
        check_reset_outputs("in_reset");
        log_rst = 1'b0;
        tick();
        check_reset_outputs("after_reset");

        // single query answered ready, with exact packet image
        clear_plan();
        exp_q.push_back(64'h00A0_2000_0001_0000);
        exp_user_q.push_back(32'h0001_0002);
        mdl_tid = 8'h01;
        plan_out[0] = OUT_READY;
        plan_dly[0] = 2;
        // run_query pushes its own model entry for tid 00; drop ours afterwards
        begin
            logic [63:0] lit_d; logic [31:0] lit_u;
            lit_d = exp_q.pop_front(); lit_u = exp_user_q.pop_front();
            mdl_tid = 8'h00;
            check("model_packet_image", query_word(8'h00) == lit_d, 1);
            run_query("basic", 16'h0001, 16'h0002);
        end

        // not-ready twice then ready
        clear_plan();
        plan_out[0] = OUT_NOTREADY; plan_out[1] = OUT_NOTREADY; plan_out[2] = OUT_READY;
        plan_dly[0] = 1; plan_dly[1] = 5;
        run_query("notready2", 16'h0001, 16'h0002);

        // no response at all: MAX_RETRY re-sends then fail
        clear_plan();
        plan_out[0] = OUT_TIMEOUT; plan_out[1] = OUT_TIMEOUT; plan_out[2] = OUT_TIMEOUT;
        run_query("timeout_fail", 16'h0011, 16'h0022);

        // last attempt not-ready also fails
        clear_plan();
        plan_out[0] = OUT_NOTREADY; plan_out[1] = OUT_TIMEOUT; plan_out[2] = OUT_NOTREADY;
        run_query("mixed_fail", 16'h0003, 16'h0004);

        // request channel stalled for 10 cycles
        clear_plan();
        plan_stall[0] = 10;
        run_query("stall10", 16'h0100, 16'h0200);

        // ready arriving on the very cycle the timer expires
        clear_plan();
        plan_dly[0] = T - 1;
        run_query("ready_at_expiry", 16'h0007, 16'h0008);

        // ignored beats: non-first beat, wrong source, unknown info
        src_id = 16'h0001; des_id = 16'h0002;
        base_done = done_cnt;
        ireq_tready_in = 1'b1;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        ireq_tready_in = 1'b0;
        exp_q.push_back(query_word(mdl_tid)); exp_user_q.push_back(32'h0001_0002); mdl_tid++;
        send_beat(resp_word(4'h5, 16'h0100), 32'h0002_0001, 1'b0);
        check("ign_nwrite_first", done_o, 0);
        send_beat(resp_word(4'hA, 16'h0100), 32'h0002_0001, 1'b1);
        check("ign_nwrite_second", done_o, 0);
        send_beat(resp_word(4'hA, 16'h0100), 32'h0005_0001, 1'b1);
        check("ign_wrong_src", done_o, 0);
        send_beat(resp_word(4'hA, 16'h1234), 32'h0002_0001, 1'b1);
        check("ign_other_info", done_o, 0);
        tick();
        check("ign_still_busy", busy_o, 1);
        check("ign_no_resend", ireq_tvalid_o, 0);
        send_beat(resp_word(4'hA, 16'h0100), 32'h0002_0001, 1'b1);
        check("ign_valid_done", done_o, 1);
        check("ign_ready_flag", ed_ready_o, 1);
        tick();
        check("ign_done_count", done_cnt - base_done, 1);
        drain_scoreboard("ignore");

        // reset during WAIT_RESP aborts silently and restarts tid
        base_done = done_cnt;
        base_fail = fail_cnt;
        ireq_tready_in = 1'b1;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        ireq_tready_in = 1'b0;
        exp_q.push_back(query_word(mdl_tid)); exp_user_q.push_back(32'h0001_0002); mdl_tid++;
        repeat (3) tick();
        log_rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        log_rst = 1'b0;
        repeat (T + RG + 4) tick();
        check_reset_outputs("post_abort");
        check("abort_no_done", done_cnt - base_done, 0);
        check("abort_no_fail", fail_cnt - base_fail, 0);
        drain_scoreboard("abort");
        mdl_tid = 8'h00;
        clear_plan();
        run_query("after_reset", 16'h0001, 16'h0002);

        // randomized queries
        for (int q = 0; q < 20; q++) begin
            for (int i = 0; i < 8; i++) begin
                plan_out[i]    = $urandom_range(0, 2);
                plan_stall[i]  = $urandom_range(0, 3);
                plan_dly[i]    = $urandom_range(0, T - 1);
                plan_glitch[i] = ($urandom_range(0, 3) == 0);
            end
            rs = 16'($urandom_range(0, 65535));
            rd = 16'($urandom_range(0, 65535));
            run_query("rand", rs, rd);
        end

        check("never_done_and_fail", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
